jtframe_wirebw_sched: RTL and testbench



---
 rtl/jtframe_wirebw_pkg.sv | 33 +++
 rtl/jtframe_wirebw_tapbuf.sv | 35 +++
 rtl/jtframe_wirebw_sched.sv | 193 +++++++++++++++++++
 tb/tb_jtframe_wirebw_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_wirebw_pkg.sv
// Shared types, defaults and helpers for the wire-bandwidth filter scheduler.
package jtframe_wirebw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIN  = 4;
    localparam int unsigned DEF_WOUT = 5;
    localparam int unsigned DEF_WC   = 5;
    localparam int unsigned DEF_N    = 5;

    // Tap 0 sits in the least significant bits
    localparam logic [DEF_N*DEF_WC-1:0] DEF_COEFF = {5'd0, 5'd7, 5'd20, 5'd7, 5'd0};

    // Working width of ext(); wide enough for any sensible colour depth
    localparam int unsigned EXT_W = 16;

    // Accumulator width: product width plus headroom for up to 8 taps
    function automatic int unsigned aw_calc(input int unsigned win, input int unsigned wc);
        return win + wc + 3;
    endfunction

    // Widen a colour by replicating its top bits into the new LSBs
    function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] x,
                                             input int unsigned       win,
                                             input int unsigned       wout);
        return (x << (wout - win)) | (x >> (2*win - wout));
    endfunction

endpackage

// File: rtl/jtframe_wirebw_tapbuf.sv
// One channel's sample history: N-deep shift register with an indexed read port.
module jtframe_wirebw_tapbuf #(
    parameter  int unsigned WIN = 4,
    parameter  int unsigned N   = 5,
    localparam int unsigned TW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shift,
    input  logic [WIN-1:0] din,
    input  logic [TW-1:0]  idx,
    output logic [WIN-1:0] dout
);

    logic [WIN-1:0] hist [N];

    // Newest sample enters at tap 0, oldest falls off the end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) hist[i] <= '0;
        end else if (shift) begin
            hist[0] <= din;
            for (int i = 1; i < int'(N); i++) hist[i] <= hist[i-1];
        end
    end

    // Explicit compare mux so a non power-of-two depth never reads out of range
    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (idx == TW'(i)) dout = hist[i];
        end
    end

endmodule

// File: rtl/jtframe_wirebw_sched.sv
// Time-shared MAC scheduler for the wire-bandwidth video filter.
// One multiplier walks R, G then B for every sample strobe and commits all
// three results on the same edge. Optional macro JTFRAME_WIREBW_SYNCDLY_EN
// adds a 4-sample sync delay line (used only while filtering).
module jtframe_wirebw_sched
    import jtframe_wirebw_pkg::*;
#(
    parameter int unsigned       WIN   = DEF_WIN,
    parameter int unsigned       WOUT  = DEF_WOUT,
    parameter int unsigned       WC    = DEF_WC,
    parameter int unsigned       N     = DEF_N,
    parameter logic [N*WC-1:0]   COEFF = (N*WC)'(DEF_COEFF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            spl_in,
    input  logic            enable,
    input  logic [WIN-1:0]  r_in,
    input  logic [WIN-1:0]  g_in,
    input  logic [WIN-1:0]  b_in,
    input  logic [3:0]      sync_in,
    output logic [WOUT-1:0] r_out,
    output logic [WOUT-1:0] g_out,
    output logic [WOUT-1:0] b_out,
    output logic [3:0]      sync_out,
    output logic            busy,
    output logic            overrun
);

    localparam int unsigned AW = aw_calc(WIN, WC);
    localparam int unsigned TW = $clog2(N);
    localparam int unsigned PW = WC + WIN;
    localparam int unsigned SH = WC - (WOUT - WIN);
    localparam logic [AW-1:0] OMAX = AW'((1 << WOUT) - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   acc, acc_nxt;
    logic [1:0]      ch, ch_nxt;
    logic [TW-1:0]   tap, tap_nxt;
    logic [WOUT-1:0] pend_r, pend_r_nxt, pend_g, pend_g_nxt;
    logic [WOUT-1:0] res_r, res_r_nxt, res_g, res_g_nxt, res_b, res_b_nxt;
    logic            busy_nxt, overrun_nxt;

    logic [WIN-1:0]  tap_r, tap_g, tap_b, sample;
    logic [WC-1:0]   coef;
    logic [PW-1:0]   prod;
    logic [AW-1:0]   shifted;
    logic [WOUT-1:0] result;

    jtframe_wirebw_tapbuf #(.WIN(WIN), .N(N)) u_tap_r (
        .clk(clk), .rst(rst), .shift(spl_in), .din(r_in), .idx(tap), .dout(tap_r)
    );
    jtframe_wirebw_tapbuf #(.WIN(WIN), .N(N)) u_tap_g (
        .clk(clk), .rst(rst), .shift(spl_in), .din(g_in), .idx(tap), .dout(tap_g)
    );
    jtframe_wirebw_tapbuf #(.WIN(WIN), .N(N)) u_tap_b (
        .clk(clk), .rst(rst), .shift(spl_in), .din(b_in), .idx(tap), .dout(tap_b)
    );

    // Shared datapath: operand select, product and saturated result
    always_comb begin
        case (ch)
            2'd0:    sample = tap_r;
            2'd1:    sample = tap_g;
            default: sample = tap_b;
        endcase
        coef = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (tap == TW'(i)) coef = COEFF[i*WC +: WC];
        end
        prod    = PW'(coef) * PW'(sample);
        shifted = acc >> SH;
        result  = (shifted > OMAX) ? '1 : WOUT'(shifted);
    end

    // Next-state and sequencing; a strobe always overrides the walk in progress
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        ch_nxt      = ch;
        tap_nxt     = tap;
        pend_r_nxt  = pend_r;
        pend_g_nxt  = pend_g;
        res_r_nxt   = res_r;
        res_g_nxt   = res_g;
        res_b_nxt   = res_b;
        busy_nxt    = busy;
        overrun_nxt = overrun;

        case (state)
            MAC: begin
                acc_nxt = acc + AW'(prod);
                if (tap == TW'(N - 1)) begin
                    tap_nxt   = '0;
                    state_nxt = STORE;
                end else begin
                    tap_nxt = tap + TW'(1);
                end
            end
            STORE: begin
                acc_nxt = '0;
                tap_nxt = '0;
                case (ch)
                    2'd0: begin
                        pend_r_nxt = result;
                        ch_nxt     = 2'd1;
                        state_nxt  = MAC;
                    end
                    2'd1: begin
                        pend_g_nxt = result;
                        ch_nxt     = 2'd2;
                        state_nxt  = MAC;
                    end
                    default: begin
                        res_r_nxt = pend_r;
                        res_g_nxt = pend_g;
                        res_b_nxt = result;
                        ch_nxt    = 2'd0;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                endcase
            end
            default: ;
        endcase

        if (spl_in) begin
            if (busy) overrun_nxt = 1'b1;
            // Outputs keep their last committed value when a walk is cut short
            res_r_nxt = res_r;
            res_g_nxt = res_g;
            res_b_nxt = res_b;
            acc_nxt   = '0;
            ch_nxt    = 2'd0;
            tap_nxt   = '0;
            state_nxt = enable ? MAC : IDLE;
            busy_nxt  = enable;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            ch      <= '0;
            tap     <= '0;
            pend_r  <= '0;
            pend_g  <= '0;
            res_r   <= '0;
            res_g   <= '0;
            res_b   <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            ch      <= ch_nxt;
            tap     <= tap_nxt;
            pend_r  <= pend_r_nxt;
            pend_g  <= pend_g_nxt;
            res_r   <= res_r_nxt;
            res_g   <= res_g_nxt;
            res_b   <= res_b_nxt;
            busy    <= busy_nxt;
            overrun <= overrun_nxt;
        end
    end

    // Bypass follows the live enable so it takes effect without waiting a sample
    assign r_out = enable ? res_r : WOUT'(ext(EXT_W'(r_in), WIN, WOUT));
    assign g_out = enable ? res_g : WOUT'(ext(EXT_W'(g_in), WIN, WOUT));
    assign b_out = enable ? res_b : WOUT'(ext(EXT_W'(b_in), WIN, WOUT));

`ifdef JTFRAME_WIREBW_SYNCDLY_EN
    logic [3:0] sync_dly [4];

    // Sync delay line advancing once per sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) sync_dly[i] <= '0;
        end else if (spl_in) begin
            sync_dly[0] <= sync_in;
            for (int i = 1; i < 4; i++) sync_dly[i] <= sync_dly[i-1];
        end
    end

    assign sync_out = enable ? sync_dly[3] : sync_in;
`else
    assign sync_out = sync_in;
`endif

endmodule

// File: tb/tb_jtframe_wirebw_sched.sv
// Scoreboard bench for jtframe_wirebw_sched with a sum-of-products reference model.
module tb_jtframe_wirebw_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       spl_in;
    logic       enable;
    logic [3:0] r_in, g_in, b_in, sync_in;
    logic [4:0] r_out, g_out, b_out;
    logic [3:0] sync_out;
    logic       busy, overrun;

    jtframe_wirebw_sched dut (
        .clk(clk), .rst(rst), .spl_in(spl_in), .enable(enable),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .sync_in(sync_in),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .sync_out(sync_out),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned r, g, b, at;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned hr[$], hg[$], hb[$];
    int unsigned sq[$];
    int unsigned coef [5] = '{0, 7, 20, 7, 0};
    int unsigned busy_end = 0;
    bit          ovr_m = 0;
    int unsigned imp_exp [5] = '{0, 6, 18, 6, 0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned filt(input int unsigned h[$]);
        int unsigned s = 0;
        for (int k = 0; k < 5; k++) s += coef[k] * h[k];
        s = s / 16;
        return (s > 31) ? 31 : s;
    endfunction

    function automatic int unsigned widen(input int unsigned x);
        return (x * 2) + (x / 8);
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        sb.delete(); hr.delete(); hg.delete(); hb.delete(); sq.delete();
        for (int k = 0; k < 5; k++) begin hr.push_back(0); hg.push_back(0); hb.push_back(0); end
        for (int k = 0; k < 4; k++) sq.push_back(0);
        busy_end = 0;
        ovr_m    = 0;
    endtask

    task automatic check_sync();
`ifdef JTFRAME_WIREBW_SYNCDLY_EN
        check("sync_out", sync_out, enable ? sq[3] : int'(sync_in));
`else
        check("sync_out", sync_out, sync_in);
`endif
    endtask

    // Called just after a negedge; returns just after the negedge following the strobe edge
    task automatic strobe(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                          input logic [3:0] s, input bit en);
        int unsigned e_edge;
        exp_t x;
        r_in = r; g_in = g; b_in = b; sync_in = s; enable = en; spl_in = 1'b1;
        e_edge = cyc + 1;
        if (busy_end != 0 && e_edge <= busy_end) begin
            ovr_m = 1;
            if (sb.size() > 0) void'(sb.pop_back());
        end
        hr.push_front(int'(r)); void'(hr.pop_back());
        hg.push_front(int'(g)); void'(hg.pop_back());
        hb.push_front(int'(b)); void'(hb.pop_back());
        sq.push_front(int'(s)); void'(sq.pop_back());
        if (en) begin
            x.r = filt(hr); x.g = filt(hg); x.b = filt(hb); x.at = e_edge + 18;
            sb.push_back(x);
            busy_end = x.at;
        end else begin
            busy_end = 0;
        end
        @(negedge clk);
        spl_in = 1'b0;
        check("busy_after_strobe", busy, en);
        check("overrun_flag", overrun, ovr_m);
        check_sync();
        if (!en) begin
            check("bypass_r", r_out, widen(r));
            check("bypass_g", g_out, widen(g));
            check("bypass_b", b_out, widen(b));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every busy fall is a commit; compare against the oldest expectation
    logic [4:0] prev_r = '0, prev_g = '0, prev_b = '0;
    bit         prev_busy = 0, prev_rst = 1, prev_en = 0;
    always @(posedge clk) begin
        bit commit;
        #1;
        commit = (!rst && prev_busy && !busy);
        if (commit) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("commit_cycle", cyc, mon_e.at);
                if (enable) begin
                    check("filt_r", r_out, mon_e.r);
                    check("filt_g", g_out, mon_e.g);
                    check("filt_b", b_out, mon_e.b);
                end
            end
        end
        if (!rst && !prev_rst && enable && prev_en)
            check("atomic_update",
                  ((r_out !== prev_r) || (g_out !== prev_g) || (b_out !== prev_b)) && !commit, 0);
        prev_r = r_out; prev_g = g_out; prev_b = b_out;
        prev_busy = busy; prev_rst = rst; prev_en = enable;
    end

    initial begin
        bit          en_next;
        int unsigned gap;
        rst = 1'b1; spl_in = 1'b0; enable = 1'b1;
        r_in = '0; g_in = '0; b_in = '0; sync_in = '0;
        model_reset();
        tick(3);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_r", r_out, 0);
        check("reset_g", g_out, 0);
        check("reset_b", b_out, 0);

        // Constant full scale
        for (int i = 0; i < 6; i++) begin strobe(4'd15, 4'd15, 4'd15, 4'h0, 1'b1); tick(19); end
        check("const15_r", r_out, 31);
        check("const15_b", b_out, 31);

        // Constant mid scale, filtered and bypassed agree
        for (int i = 0; i < 6; i++) begin strobe(4'd8, 4'd8, 4'd8, 4'h0, 1'b1); tick(19); end
        check("const8_filt", r_out, 17);
        enable = 1'b0; #1;
        check("const8_bypass", r_out, 17);
        enable = 1'b1; #1;
        check("const8_back", r_out, 17);
        @(negedge clk);

        // Impulse on red only
        for (int i = 0; i < 5; i++) begin strobe(4'd0, 4'd0, 4'd0, 4'h0, 1'b1); tick(19); end
        for (int i = 0; i < 5; i++) begin
            strobe((i == 0) ? 4'd15 : 4'd0, 4'd0, 4'd0, 4'h0, 1'b1);
            tick(19);
            check("impulse_r", r_out, imp_exp[i]);
            check("impulse_g", g_out, 0);
        end

        // Strobe 10 clk after the previous one
        strobe(4'd7, 4'd3, 4'd12, 4'h5, 1'b1);
        tick(9);
        strobe(4'd11, 4'd2, 4'd9, 4'ha, 1'b1);
        check("overrun_set", overrun, 1);
        tick(19);
        check("overrun_sticky", overrun, 1);

        // Reset in the middle of a walk
        strobe(4'd5, 4'd6, 4'd7, 4'h3, 1'b1);
        tick(5);
        check("busy_mid", busy, 1);
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_r", r_out, 0);
        check("rst_g", g_out, 0);
        check("rst_b", b_out, 0);

        // Bypass
        enable = 1'b0; r_in = 4'd9; #1;
        check("bypass9", r_out, 19);
        @(negedge clk);
        strobe(4'd9, 4'd1, 4'd14, 4'hc, 1'b0);
        tick(19);

        // Random traffic with occasional early strobes
        en_next = 1;
        for (int i = 0; i < 40; i++) begin
            strobe(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), en_next);
            en_next = ($urandom_range(3, 0) != 0);
            if (en_next && $urandom_range(7, 0) == 0) gap = $urandom_range(16, 5);
            else gap = $urandom_range(24, 19);
            tick(int'(gap) - 1);
        end
        enable = 1'b1;
        tick(25);
        check("scoreboard_empty", sb.size(), 0);
        check("final_overrun", overrun, ovr_m);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
